// File: rtl/fxp_divider_seq_if.sv
// Request/response bundle for the sequential fixed-point divider.
// The master issues operands and start; the slave returns status and results.
interface fxp_divider_seq_if #(
  parameter int W = 10
);
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] q_out;
  logic [W-1:0] rem_out;
  logic         dvz;
  logic         ovf;

  modport master (
    output start, a_in, b_in,
    input  busy, done, q_out, rem_out, dvz, ovf
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, q_out, rem_out, dvz, ovf
  );
endinterface

// File: rtl/fxp_divider_seq.sv
// Restoring shift/subtract fixed-point divider: W-bit quotient with F fractional
// bits after W+F iterations, optional two's-complement operands.
module fxp_divider_seq #(
  parameter int W      = 10,
  parameter int F      = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                sclr,
  fxp_divider_seq_if.slave    bus
);

  localparam int QW = W + F;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_load;
  logic            w_calc;
  logic            w_fin;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_bmag;
  logic [W-1:0]    r_acc;
  logic [QW-1:0]   r_q;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_aneg;

  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_q_out;
  logic [W-1:0]    r_rem_out;
  logic            r_dvz;
  logic            r_ovf;

  logic [W-1:0]    w_amag;
  logic [W-1:0]    w_bmag;
  logic [QW-1:0]   w_a_ext;
  logic [QW-1:0]   w_q_load;
  logic [W:0]      w_shift;
  logic            w_ge;
  logic [W-1:0]    w_diff;

  logic [QW-1:0]   w_lim_pos;
  logic [QW-1:0]   w_lim;
  logic [W-1:0]    w_min_neg;
  logic [W-1:0]    w_max_pos;
  logic [W-1:0]    w_q_res;
  logic [W-1:0]    w_rem_res;
  logic            w_dvz_res;
  logic            w_ovf_res;

  // W bits suffice for |x|: the most negative input maps to 2^(W-1) read unsigned.
  function automatic logic [W-1:0] f_mag(input logic [W-1:0] v);
    if (SIGNED && v[W-1]) begin
      f_mag = ~v + W'(1);
    end else begin
      f_mag = v;
    end
  endfunction

  function automatic logic [W-1:0] f_neg(input logic [W-1:0] v);
    f_neg = ~v + W'(1);
  endfunction

  assign w_amag    = f_mag(r_a);
  assign w_bmag    = f_mag(r_b);
  assign w_shift   = {r_acc, r_q[QW-1]};
  assign w_ge      = (w_shift >= {1'b0, r_bmag});
  assign w_diff    = w_shift[W-1:0] - r_bmag;
  assign w_lim_pos = (QW'(1) << (W - 1)) - QW'(1);
  assign w_lim     = r_sign ? (w_lim_pos + QW'(1)) : w_lim_pos;
  assign w_min_neg = {1'b1, {(W-1){1'b0}}};
  assign w_max_pos = {1'b0, {(W-1){1'b1}}};

  // Dividend magnitude placed F bits up in the quotient register.
  always_comb begin
    w_a_ext         = '0;
    w_a_ext[W-1:0]  = w_amag;
    w_q_load        = w_a_ext << F;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_calc      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = LOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        if (w_bmag == '0) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_calc = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = FIN;
        end else begin
          w_state_nxt = CALC;
        end
      end
      FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and the shift/subtract iteration.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_a    <= '0;
      r_b    <= '0;
      r_bmag <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_aneg <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= bus.a_in;
        r_b <= bus.b_in;
      end
      if (w_load) begin
        r_q    <= w_q_load;
        r_acc  <= '0;
        r_bmag <= w_bmag;
        r_sign <= SIGNED & (r_a[W-1] ^ r_b[W-1]);
        r_aneg <= SIGNED & r_a[W-1];
        r_cnt  <= CW'(QW);
      end else if (w_calc) begin
        r_acc  <= w_ge ? w_diff : w_shift[W-1:0];
        r_q    <= {r_q[QW-2:0], w_ge};
        r_cnt  <= r_cnt - CW'(1);
      end
    end
  end

  // Saturation, sign restore and divide-by-zero substitution of the final result.
  always_comb begin
    w_q_res   = '0;
    w_rem_res = '0;
    w_dvz_res = 1'b0;
    w_ovf_res = 1'b0;
    if (r_bmag == '0) begin
      w_dvz_res = 1'b1;
      if (SIGNED) begin
        w_q_res = r_aneg ? w_min_neg : w_max_pos;
      end else begin
        w_q_res = '1;
      end
    end else if (SIGNED) begin
      w_ovf_res = (r_q > w_lim);
      if (w_ovf_res) begin
        w_q_res = r_sign ? w_min_neg : w_max_pos;
      end else begin
        w_q_res = r_sign ? f_neg(r_q[W-1:0]) : r_q[W-1:0];
      end
      w_rem_res = r_aneg ? f_neg(r_acc) : r_acc;
    end else begin
      w_ovf_res = ((r_q >> W) != '0);
      w_q_res   = w_ovf_res ? '1 : r_q[W-1:0];
      w_rem_res = r_acc;
    end
  end

  // Registered status and results; results persist until the next FIN.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_q_out   <= '0;
      r_rem_out <= '0;
      r_dvz     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (w_fin) begin
        r_busy <= 1'b0;
      end
      if (w_fin) begin
        r_q_out   <= w_q_res;
        r_rem_out <= w_rem_res;
        r_dvz     <= w_dvz_res;
        r_ovf     <= w_ovf_res;
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.q_out   = r_q_out;
  assign bus.rem_out = r_rem_out;
  assign bus.dvz     = r_dvz;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_fxp_divider_seq.sv
// Directed bench for fxp_divider_seq (W=10, F=4): one unsigned and one signed instance,
// hand-computed expected results and latencies.
module tb_fxp_divider_seq;

  logic clk = 1'b0;
  logic sclr;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat;
  int   ndone;

  always #5 clk = ~clk;

  fxp_divider_seq_if #(.W(10)) u_if();
  fxp_divider_seq_if #(.W(10)) s_if();

  fxp_divider_seq #(.W(10), .F(4), .SIGNED(1'b0)) u_dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (u_if.slave)
  );

  fxp_divider_seq #(.W(10), .F(4), .SIGNED(1'b1)) s_dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (s_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and return the number of edges from the start edge to done.
  task automatic op(input bit sgn, input logic [9:0] a, input logic [9:0] b, output int l);
    if (sgn) begin
      s_if.a_in = a; s_if.b_in = b; s_if.start = 1'b1;
    end else begin
      u_if.a_in = a; u_if.b_in = b; u_if.start = 1'b1;
    end
    @(posedge clk); #1;
    u_if.start = 1'b0; s_if.start = 1'b0;
    u_if.a_in = 10'h2AA; u_if.b_in = 10'h155;
    s_if.a_in = 10'h2AA; s_if.b_in = 10'h155;
    l = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if ((sgn ? s_if.done : u_if.done) === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic check_res(input bit sgn, input string tag, input int l, input int el,
                           input logic [9:0] q, input logic [9:0] rem,
                           input logic dvz, input logic ovf);
    chk({tag, " latency"}, 32'(l), 32'(el));
    if (sgn) begin
      chk({tag, " q_out"},   {22'd0, s_if.q_out},   {22'd0, q});
      chk({tag, " rem_out"}, {22'd0, s_if.rem_out}, {22'd0, rem});
      chk({tag, " dvz"},     {31'd0, s_if.dvz},     {31'd0, dvz});
      chk({tag, " ovf"},     {31'd0, s_if.ovf},     {31'd0, ovf});
      chk({tag, " busy"},    {31'd0, s_if.busy},    32'd0);
    end else begin
      chk({tag, " q_out"},   {22'd0, u_if.q_out},   {22'd0, q});
      chk({tag, " rem_out"}, {22'd0, u_if.rem_out}, {22'd0, rem});
      chk({tag, " dvz"},     {31'd0, u_if.dvz},     {31'd0, dvz});
      chk({tag, " ovf"},     {31'd0, u_if.ovf},     {31'd0, ovf});
      chk({tag, " busy"},    {31'd0, u_if.busy},    32'd0);
    end
  endtask

  initial begin
    sclr = 1'b1;
    u_if.start = 1'b0; u_if.a_in = 10'd0; u_if.b_in = 10'd0;
    s_if.start = 1'b0; s_if.a_in = 10'd0; s_if.b_in = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy",  {31'd0, u_if.busy},    32'd0);
    chk("reset done",  {31'd0, u_if.done},    32'd0);
    chk("reset q",     {22'd0, u_if.q_out},   32'd0);
    chk("reset rem",   {22'd0, u_if.rem_out}, 32'd0);
    chk("reset dvz",   {31'd0, u_if.dvz},     32'd0);
    chk("reset ovf",   {31'd0, u_if.ovf},     32'd0);
    chk("reset s q",   {22'd0, s_if.q_out},   32'd0);
    sclr = 1'b0;

    // Unsigned basic results, back-to-back issue in the done cycle.
    op(1'b0, 10'd7, 10'd2, lat);
    check_res(1'b0, "u 7/2", lat, 16, 10'h038, 10'd0, 1'b0, 1'b0);
    op(1'b0, 10'd10, 10'd3, lat);
    check_res(1'b0, "u 10/3", lat, 16, 10'h035, 10'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("u done pulse width", {31'd0, u_if.done}, 32'd0);
    op(1'b0, 10'd0, 10'd5, lat);
    check_res(1'b0, "u 0/5", lat, 16, 10'h000, 10'd0, 1'b0, 1'b0);

    // Divide by zero, then overflow and the largest non-overflowing dividend.
    op(1'b0, 10'd9, 10'd0, lat);
    check_res(1'b0, "u 9/0", lat, 2, 10'h3FF, 10'd0, 1'b1, 1'b0);
    op(1'b0, 10'd1023, 10'd1, lat);
    check_res(1'b0, "u 1023/1", lat, 16, 10'h3FF, 10'd0, 1'b0, 1'b1);
    op(1'b0, 10'd63, 10'd1, lat);
    check_res(1'b0, "u 63/1", lat, 16, 10'h3F0, 10'd0, 1'b0, 1'b0);

    // Signed mode.
    op(1'b1, 10'h3F9, 10'd2, lat);
    check_res(1'b1, "s -7/2", lat, 16, 10'h3C8, 10'd0, 1'b0, 1'b0);
    op(1'b1, 10'h200, 10'd1, lat);
    check_res(1'b1, "s -512/1", lat, 16, 10'h200, 10'd0, 1'b0, 1'b1);
    op(1'b1, 10'd511, 10'h3FF, lat);
    check_res(1'b1, "s 511/-1", lat, 16, 10'h200, 10'd0, 1'b0, 1'b1);
    op(1'b1, 10'h3FB, 10'd3, lat);
    check_res(1'b1, "s -5/3", lat, 16, 10'h3E6, 10'h3FE, 1'b0, 1'b0);
    op(1'b1, 10'h3FB, 10'd0, lat);
    check_res(1'b1, "s -5/0", lat, 2, 10'h200, 10'd0, 1'b1, 1'b0);
    op(1'b1, 10'd5, 10'd0, lat);
    check_res(1'b1, "s 5/0", lat, 2, 10'h1FF, 10'd0, 1'b1, 1'b0);

    // A start pulse in the middle of CALC must be ignored.
    u_if.a_in = 10'd10; u_if.b_in = 10'd3; u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (u_if.done === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 5) begin
        chk("u busy mid calc", {31'd0, u_if.busy}, 32'd1);
        u_if.a_in = 10'd7; u_if.b_in = 10'd2; u_if.start = 1'b1;
      end else begin
        u_if.start = 1'b0;
      end
    end
    check_res(1'b0, "u ignore start", lat, 16, 10'h035, 10'd1, 1'b0, 1'b0);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (u_if.done === 1'b1) ndone++;
    end
    chk("u no queued op", 32'(ndone), 32'd0);

    // Synchronous clear on cycle 8 of an operation discards it.
    u_if.a_in = 10'd7; u_if.b_in = 10'd2; u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    chk("sclr busy", {31'd0, u_if.busy},    32'd0);
    chk("sclr done", {31'd0, u_if.done},    32'd0);
    chk("sclr q",    {22'd0, u_if.q_out},   32'd0);
    chk("sclr rem",  {22'd0, u_if.rem_out}, 32'd0);
    chk("sclr s q",  {22'd0, s_if.q_out},   32'd0);
    chk("sclr s dvz", {31'd0, s_if.dvz},    32'd0);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (u_if.done === 1'b1) ndone++;
    end
    chk("sclr no done", 32'(ndone), 32'd0);
    op(1'b0, 10'd7, 10'd2, lat);
    check_res(1'b0, "u restart 7/2", lat, 16, 10'h038, 10'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
